// File: rtl/odd_rf_fetch.sv
// Register fetch / operand forwarding stage feeding the odd-pipe Permute unit.
// Build option: define ODD_RF_WB_BYPASS_EN to enable the write-back bypass (narrower hazard window).
`timescale 1ns/1ps
module odd_rf_fetch (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:10]      in_op,
    input  logic [2:0]       in_format,
    input  logic [0:6]       in_ra_addr,
    input  logic [0:6]       in_rb_addr,
    input  logic [0:6]       in_rt_addr,
    input  logic [0:17]      in_imm,
    input  logic             in_reg_write,
    input  logic             flush,
    input  logic [3:0][0:6]  pend_addr,
    input  logic [3:0]       pend_write,
    input  logic [0:127]     wb_rt,
    input  logic [0:6]       wb_rt_addr,
    input  logic             wb_reg_write,
    output logic [0:10]      op,
    output logic [2:0]       format,
    output logic [0:6]       rt_addr,
    output logic [0:17]      imm,
    output logic             reg_write,
    output logic [0:127]     ra,
    output logic [0:127]     rb,
    output logic             branch_taken,
    output logic [31:0]      stall_count
);

`ifdef ODD_RF_WB_BYPASS_EN
    localparam int unsigned HAZ_DEPTH = 2;
`else
    localparam int unsigned HAZ_DEPTH = 3;
`endif

    logic [0:127] rf [0:127];
    logic [0:127] ra_sel, rb_sel;
    logic         ra_haz, rb_haz, stall;
    logic [31:0]  stall_cnt;

    always_comb begin
        ra_haz = 1'b0;
        rb_haz = 1'b0;
        for (int unsigned k = 0; k < HAZ_DEPTH; k++) begin
            if (pend_write[k] && pend_addr[k] == in_ra_addr) ra_haz = 1'b1;
            if (pend_write[k] && pend_addr[k] == in_rb_addr) rb_haz = 1'b1;
        end
`ifndef ODD_RF_WB_BYPASS_EN
        // Without the bypass a value being written this cycle is not yet readable.
        if (wb_reg_write && wb_rt_addr == in_ra_addr) ra_haz = 1'b1;
        if (wb_reg_write && wb_rt_addr == in_rb_addr) rb_haz = 1'b1;
`endif
        stall    = in_valid && (ra_haz || rb_haz);
        in_ready = flush || !stall;
    end

    always_comb begin
        ra_sel = rf[in_ra_addr];
        rb_sel = rf[in_rb_addr];
`ifdef ODD_RF_WB_BYPASS_EN
        if (wb_reg_write && wb_rt_addr == in_ra_addr) ra_sel = wb_rt;
        if (wb_reg_write && wb_rt_addr == in_rb_addr) rb_sel = wb_rt;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 128; i++) rf[i] <= '0;
        end else if (wb_reg_write) begin
            rf[wb_rt_addr] <= wb_rt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op           <= '0;
            format       <= '0;
            rt_addr      <= '0;
            imm          <= '0;
            reg_write    <= 1'b0;
            ra           <= '0;
            rb           <= '0;
            branch_taken <= 1'b0;
        end else if (!flush && in_valid && !stall) begin
            op           <= in_op;
            format       <= in_format;
            rt_addr      <= in_rt_addr;
            imm          <= in_imm;
            reg_write    <= in_reg_write;
            ra           <= ra_sel;
            rb           <= rb_sel;
            branch_taken <= 1'b0;
        end else begin
            op           <= '0;
            format       <= '0;
            rt_addr      <= '0;
            imm          <= '0;
            reg_write    <= 1'b0;
            ra           <= '0;
            rb           <= '0;
            branch_taken <= flush;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_count = stall_cnt;

endmodule

// File: tb/tb_odd_rf_fetch.sv
// Randomized self-checking bench for odd_rf_fetch against a behavioural model.
`timescale 1ns/1ps
module tb_odd_rf_fetch;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [0:10]      in_op;
    logic [2:0]       in_format;
    logic [0:6]       in_ra_addr, in_rb_addr, in_rt_addr;
    logic [0:17]      in_imm;
    logic             in_reg_write;
    logic             flush;
    logic [3:0][0:6]  pend_addr;
    logic [3:0]       pend_write;
    logic [0:127]     wb_rt;
    logic [0:6]       wb_rt_addr;
    logic             wb_reg_write;
    logic [0:10]      op;
    logic [2:0]       format;
    logic [0:6]       rt_addr;
    logic [0:17]      imm;
    logic             reg_write;
    logic [0:127]     ra, rb;
    logic             branch_taken;
    logic [31:0]      stall_count;

    odd_rf_fetch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_format(in_format), .in_ra_addr(in_ra_addr),
        .in_rb_addr(in_rb_addr), .in_rt_addr(in_rt_addr), .in_imm(in_imm),
        .in_reg_write(in_reg_write), .flush(flush), .pend_addr(pend_addr),
        .pend_write(pend_write), .wb_rt(wb_rt), .wb_rt_addr(wb_rt_addr),
        .wb_reg_write(wb_reg_write), .op(op), .format(format), .rt_addr(rt_addr),
        .imm(imm), .reg_write(reg_write), .ra(ra), .rb(rb),
        .branch_taken(branch_taken), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [127:0] mrf [128];
    logic [31:0]  m_cnt;
    logic [10:0]  e_op;
    logic [2:0]   e_fmt;
    logic [6:0]   e_rt;
    logic [17:0]  e_imm;
    logic         e_rw, e_bt;
    logic [127:0] e_ra, e_rb;
    logic         last_ready;

`ifdef ODD_RF_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // A source is blocked if a producer still sits in a stage whose result is not yet reachable.
    function automatic bit blocked(input logic [6:0] src);
        int window = BYPASS ? 2 : 3;
        for (int k = 0; k < window; k++)
            if (pend_write[k] && pend_addr[k] == src) return 1'b1;
        if (!BYPASS && wb_reg_write && wb_rt_addr == src) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [127:0] operand(input logic [6:0] src);
        if (BYPASS && wb_reg_write && wb_rt_addr == src) return wb_rt;
        return mrf[src];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mrf[i] = '0;
        m_cnt = 0; e_op = 0; e_fmt = 0; e_rt = 0; e_imm = 0;
        e_rw = 0; e_bt = 0; e_ra = 0; e_rb = 0;
    endtask

    task automatic check_outs();
        chk("op", op, e_op);
        chk("format", format, e_fmt);
        chk("rt_addr", rt_addr, e_rt);
        chk("imm", imm, e_imm);
        chk("reg_write", reg_write, e_rw);
        chk("ra", ra, e_ra);
        chk("rb", rb, e_rb);
        chk("branch_taken", branch_taken, e_bt);
        chk("stall_count", stall_count, m_cnt);
    endtask

    task automatic set_idle();
        in_valid = 0; in_op = 0; in_format = 0; in_ra_addr = 0; in_rb_addr = 0;
        in_rt_addr = 0; in_imm = 0; in_reg_write = 0; flush = 0;
        pend_addr = '0; pend_write = '0; wb_rt = '0; wb_rt_addr = 0; wb_reg_write = 0;
    endtask

    // Inputs are already driven (just after a negedge); runs one clock and checks everything.
    task automatic cycle();
        bit st;
        #1;
        st = in_valid && (blocked(in_ra_addr) || blocked(in_rb_addr));
        last_ready = !st || flush;
        chk("in_ready", in_ready, last_ready);
        if (!flush && in_valid && !st) begin
            e_op = in_op; e_fmt = in_format; e_rt = in_rt_addr; e_imm = in_imm;
            e_rw = in_reg_write; e_ra = operand(in_ra_addr); e_rb = operand(in_rb_addr);
            e_bt = 0;
        end else begin
            e_op = 0; e_fmt = 0; e_rt = 0; e_imm = 0; e_rw = 0; e_ra = 0; e_rb = 0;
            e_bt = flush;
        end
        if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (wb_reg_write) mrf[wb_rt_addr] = wb_rt;
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0;
        in_valid = 1; in_op = 11'h7FF; in_format = 3'h7; in_ra_addr = 7'h55; in_rb_addr = 7'h2A;
        in_rt_addr = 7'h7F; in_imm = '1; in_reg_write = 1; flush = 1; pend_addr = '1;
        pend_write = '1; wb_rt = '1; wb_rt_addr = 7'h11; wb_reg_write = 1;
        #1;
        model_clear();
        check_outs();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        reset = 1;
        set_idle();
    endtask

    localparam logic [127:0] V3  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] W7  = 128'hDEADBEEF_00000007_CAFEF00D_12345678;
    localparam logic [127:0] DEP = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    initial begin
        int stalls;
        bit accepted;
        set_idle();
        reset = 1;
        @(negedge clk);
        do_reset();

        // r5 reads zero after reset
        in_valid = 1; in_ra_addr = 5; in_rb_addr = 5; in_op = 11'h001;
        cycle();
        chk("r5_zero", ra, 128'h0);

        // Write r3 via write-back, then read it back
        set_idle();
        wb_reg_write = 1; wb_rt_addr = 3; wb_rt = V3;
        cycle();
        set_idle();
        in_valid = 1; in_op = 11'h1DC; in_ra_addr = 3; in_rb_addr = 4; in_rt_addr = 12;
        in_reg_write = 1; in_imm = 18'h2ABCD;
        cycle();
        chk("rotqby_ready", last_ready, 1'b1);
        chk("rotqby_ra", ra, V3);
        chk("rotqby_op", op, 11'h1DC);

        // Hazard on pend[0] against rb
        set_idle();
        in_valid = 1; in_op = 11'h1DC; in_ra_addr = 1; in_rb_addr = 7; in_rt_addr = 2;
        pend_addr[0] = 7; pend_write[0] = 1;
        cycle();
        chk("haz_ready", last_ready, 1'b0);
        chk("haz_nop", op, 11'h0);
        chk("haz_cnt", stall_count, 32'd1);

        // Producer reaches pend[2] together with its write-back
        pend_addr = '0; pend_write = '0;
        pend_addr[2] = 7; pend_write[2] = 1;
        wb_reg_write = 1; wb_rt_addr = 7; wb_rt = W7;
        cycle();
        if (BYPASS) chk("bypass_rb", rb, W7);
        else        chk("nobypass_stall", last_ready, 1'b0);

        // Flush while stalled
        set_idle();
        in_valid = 1; in_ra_addr = 9; pend_addr[1] = 9; pend_write[1] = 1; flush = 1;
        in_op = 11'h3AA;
        cycle();
        chk("flush_ready", last_ready, 1'b1);
        chk("flush_bt", branch_taken, 1'b1);
        chk("flush_nop", op, 11'h0);
        set_idle();
        cycle();
        chk("flush_bt_clear", branch_taken, 1'b0);

        // Dependent pair: producer walks pend[0], pend[1], pend[2]+wb, pend[3]
        set_idle();
        stalls = 0; accepted = 0;
        for (int c = 0; c < 4; c++) begin
            pend_addr = '0; pend_write = '0; wb_reg_write = 0;
            pend_addr[c] = 9; pend_write[c] = 1;
            if (c == 2) begin wb_reg_write = 1; wb_rt_addr = 9; wb_rt = DEP; end
            in_valid = !accepted; in_op = 11'h1DC; in_ra_addr = 9; in_rb_addr = 0;
            in_rt_addr = 10; in_reg_write = 1;
            cycle();
            if (in_valid && last_ready) begin
                accepted = 1;
                chk("dep_ra", ra, DEP);
            end else if (in_valid) begin
                stalls++;
            end
        end
        chk("dep_stalls", stalls, BYPASS ? 2 : 3);
        chk("dep_issued", accepted, 1'b1);

        // Randomized traffic over a small address pool to provoke hazards
        for (int n = 0; n < 400; n++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_op        = 11'($urandom);
            in_format    = 3'($urandom);
            in_ra_addr   = 7'($urandom_range(0, 7));
            in_rb_addr   = 7'($urandom_range(0, 7));
            in_rt_addr   = 7'($urandom);
            in_imm       = 18'($urandom);
            in_reg_write = 1'($urandom);
            flush        = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++) begin
                pend_addr[k]  = 7'($urandom_range(0, 7));
                pend_write[k] = ($urandom_range(0, 3) == 0);
            end
            wb_reg_write = 1'($urandom);
            wb_rt_addr   = 7'($urandom_range(0, 7));
            wb_rt        = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // Saturation of the stall counter
        set_idle();
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFF_FFFD;
        in_valid = 1; in_ra_addr = 20; pend_addr[0] = 20; pend_write[0] = 1;
        repeat (3) cycle();
        chk("sat_cnt", stall_count, 32'hFFFF_FFFF);

        // Reset mid-stall after a real issue: outputs and RF cleared immediately
        set_idle();
        wb_reg_write = 1; wb_rt_addr = 3; wb_rt = V3;
        cycle();
        set_idle();
        in_valid = 1; in_op = 11'h0F0; in_ra_addr = 3; in_rt_addr = 4; in_reg_write = 1;
        cycle();
        chk("pre_reset_ra", ra, V3);
        pend_addr[0] = 3; pend_write[0] = 1;
        #2;
        reset = 0;
        #1;
        model_clear();
        check_outs();
        @(negedge clk);
        reset = 1;
        set_idle();
        in_valid = 1; in_ra_addr = 3; in_op = 11'h001;
        cycle();
        chk("rf_lost", ra, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/odd_rf_fetch.md
# odd_rf_fetch

Register-fetch and operand-forwarding stage directly upstream of the odd-pipe Permute unit. It holds the 128 x 128-bit register file and accepts one decoded instruction per cycle. It reads ra/rb, bypasses the Permute write-back value, and stalls decode on unresolved RAW hazards against Permute's in-flight delay stages. Its registered outputs drive Permute's RF/FWD inputs one cycle after issue.

## Interface
- No parameters; register count 128, width 128, pending depth 4 are fixed.
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle (combinational, = ~stall)
- in_op  in  [0:10]  decoded opcode
- in_format  in  [2:0]  instruction format
- in_ra_addr, in_rb_addr  in  [0:6]  source register addresses
- in_rt_addr  in  [0:6]  destination address
- in_imm  in  [0:17]  immediate
- in_reg_write  in  1  instruction writes RT
- flush  in  1  branch taken; kill accepted and issuing instruction
- pend_addr  in  [3:0][0:6]  Permute rt_addr_delay
- pend_write  in  [3:0]  Permute reg_write_delay
- wb_rt  in  [0:127]  Permute rt_wb
- wb_rt_addr  in  [0:6]  Permute rt_addr_wb
- wb_reg_write  in  1  Permute reg_write_wb
- op  out  [0:10], format out [2:0], rt_addr out [0:6], imm out [0:17], reg_write out 1  registered to Permute
- ra, rb  out  [0:127]  registered operand values
- branch_taken  out  1  registered flush indication to Permute
- stall_count  out  [31:0]  saturating count of stall cycles

## Operation
- Register file: 128 entries; write on posedge when wb_reg_write, at wb_rt_addr, data wb_rt. All entries clear on reset.
- Operand select per source (ra, rb independently), priority order:
  1. wb_reg_write && wb_rt_addr == src: value is wb_rt (bypass).
  2. Otherwise: RF[src].
- Hazard: stall = in_valid && (src matches pend_addr[k] with pend_write[k], k in {0,1}) for either source. Matches on pend[2] are covered by the bypass. pend[3] is already in the RF.
- Sources are always checked, including for formats without rb; false stalls are acceptable.
- Issue (posedge, not flush):
  - in_valid && !stall: output regs load in_* and the selected operands.
  - Otherwise: nop is issued: op=0, format=0, rt_addr=0, reg_write=0, ra=rb=0, imm=0.
- Flush: when flush=1 the output registers load nop and branch_taken=1 for one cycle. The input is dropped; in_ready stays 1, so decode advances. Flush overrides stall.
- stall_count increments on every cycle with stall=1, saturates at 0xFFFFFFFF, and clears only on reset.

## Timing
- Latency: 1 cycle, input accepted at edge N, outputs valid after edge N and held until edge N+1.
- Throughput: 1 instruction/cycle absent hazards.
- Back-to-back dependent Permute ops stall 2 cycles, then issue with the bypassed value on the third.
- Same-cycle WB write and read of one address returns the new value (bypass); RF updates at the same edge.
- Reset values: all outputs 0, branch_taken=0, stall_count=0. in_ready follows the combinational stall equation.
- Reset asserted mid-stall: the pipeline register becomes nop immediately and RF contents are lost.

## Configuration
- ODD_RF_WB_BYPASS_EN defined: the bypass path and hazard window {0,1} apply as above.
- ODD_RF_WB_BYPASS_EN undefined:
  - No bypass mux; operands come only from the RF.
  - The hazard window widens to {0,1,2} and additionally includes a wb_reg_write match.
  - Dependent ops stall 3 cycles and read the RF the cycle after the write.

## Test plan
- Reset: drive reset=0 with garbage inputs -> all outputs 0, stall_count=0. After release, reading r5 returns 0.
- Write/read: WB writes r3=0x0123..EF. Next cycle issue rotqby (op 0x1DC) with ra=r3 -> ra=0x0123..EF after one edge, in_ready=1.
- Hazard: pend_addr[0]=7, pend_write[0]=1, issue with rb=7 -> in_ready=0, nop issued, stall_count +1. When the match moves to pend[2] with wb_rt_addr=7 -> rb=wb_rt (bypass build).
- Flush during stall: stall active and flush=1 -> outputs nop, branch_taken=1 for exactly one cycle, in_ready=1.
- Saturation: force stall_count near 0xFFFFFFFE, then stall 3 cycles -> stall_count holds 0xFFFFFFFF.
- Non-bypass build: the same dependent pair stalls 3 cycles and ra equals the RF-written value.
